// File: rtl/flow_bus_skid_sink.sv
// Receive buffer for an upstream that observes up_ready SKID cycles late:
// every presented word is written, and ready drops while SKID slots are still free.
module flow_bus_skid_sink #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int SKID       = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         up_ready,
    input  logic                         up_valid,
    input  logic [DATA_WIDTH-1:0]        up_data,
    input  logic                         down_ready,
    output logic                         down_valid,
    output logic [DATA_WIDTH-1:0]        down_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count_next;
    logic [CNT_W-1:0]      free_next;
    logic                  full, push, pop, drop;

    assign down_valid = (count != '0);
    assign down_data  = mem[rd_ptr];

    assign full = (count == CNT_W'(DEPTH));
    assign pop  = down_valid & down_ready;
    // A full buffer still accepts a word when the head leaves in the same cycle.
    assign push = up_valid & (~full | pop);
    assign drop = up_valid & full & ~pop;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // Ready depends only on registered state plus this cycle's push/pop, then is registered.
    assign free_next = CNT_W'(DEPTH) - count_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            up_ready <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count    <= count_next;
            up_ready <= (free_next > CNT_W'(SKID));
            if (drop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) mem[wr_ptr] <= up_data;
    end

endmodule

// File: tb/tb_flow_bus_skid_sink.sv
// Scoreboard bench for flow_bus_skid_sink: accepted words are queued and
// matched against down_data as the buffer pops them.
module tb_flow_bus_skid_sink;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int SKID  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          up_ready, up_valid, down_ready, down_valid, overflow;
    logic [DW-1:0] up_data, down_data;
    logic [3:0]    count;

    flow_bus_skid_sink #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .SKID(SKID)) dut (
        .clk(clk), .rst(rst), .up_ready(up_ready), .up_valid(up_valid), .up_data(up_data),
        .down_ready(down_ready), .down_valid(down_valid), .down_data(down_data),
        .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    int          popped = 0;
    logic [DW-1:0] q[$];
    logic        ovf_m = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Called #1 after a rising edge: drives one cycle, updates the model, checks state after the edge.
    task automatic cyc(input logic r_st, input logic v, input logic [DW-1:0] d, input logic dr);
        logic [DW-1:0] h;
        logic          rdy_exp;
        rst = r_st; up_valid = v; up_data = d; down_ready = dr;
        if (r_st) begin
            q.delete();
            ovf_m = 1'b0;
        end else begin
            chk("down_valid", {31'b0, down_valid}, {31'b0, q.size() != 0});
            if (q.size() != 0 && dr) begin
                h = q.pop_front();
                chk("down_data", {16'b0, down_data}, {16'b0, h});
                popped++;
            end
            if (v) begin
                if (q.size() < DEPTH) q.push_back(d);
                else ovf_m = 1'b1;
            end
        end
        @(posedge clk); #1;
        rdy_exp = r_st ? 1'b0 : ((DEPTH - q.size()) > SKID);
        chk("count", {28'b0, count}, q.size());
        chk("overflow", {31'b0, overflow}, {31'b0, ovf_m});
        chk("up_ready", {31'b0, up_ready}, {31'b0, rdy_exp});
    endtask

    initial begin
        int          sent;
        int          cycles;
        logic [2:0]  hist;

        rst = 1'b1; up_valid = 1'b0; up_data = '0; down_ready = 1'b0;
        @(posedge clk); #1;

        // reset with stray inputs, then release
        cyc(1, 1, 16'h5555, 1);
        chk("rst_dvalid", {31'b0, down_valid}, 32'd0);
        chk("rst_ready", {31'b0, up_ready}, 32'd0);
        cyc(0, 0, 0, 0);
        chk("ready_after_rst", {31'b0, up_ready}, 32'd1);

        // streaming pass-through, one cycle latency
        for (int i = 1; i <= 4; i++) begin
            cyc(0, 1, DW'(i), 1);
            chk("cnt_le1", {31'b0, count <= 4'd1}, 32'd1);
            chk("pass_head", {16'b0, down_data}, i);
        end
        cyc(0, 0, 0, 1);
        chk("drained", {28'b0, count}, 32'd0);

        // fill with downstream stalled; ready falls after the 6th push
        for (int k = 1; k <= 8; k++) begin
            cyc(0, 1, DW'(16'h0010 + k), 0);
            chk("ready_fill", {31'b0, up_ready}, {31'b0, k <= 5});
        end
        chk("full_cnt", {28'b0, count}, 32'd8);
        chk("full_ovf", {31'b0, overflow}, 32'd0);

        // overflow drop
        cyc(0, 1, 16'hDEAD, 0);
        chk("drop_cnt", {28'b0, count}, 32'd8);
        chk("drop_ovf", {31'b0, overflow}, 32'd1);

        // push while full with simultaneous pop; BEEF must come out last
        cyc(0, 1, 16'hBEEF, 1);
        chk("fullpp_cnt", {28'b0, count}, 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) chk("beef_last", {16'b0, down_data}, 32'h0000BEEF);
            cyc(0, 0, 0, 1);
        end
        chk("sticky_ovf", {31'b0, overflow}, 32'd1);

        // reset mid-operation at count=5
        for (int i = 0; i < 5; i++) cyc(0, 1, DW'(16'h0A00 + i), 0);
        chk("cnt5", {28'b0, count}, 32'd5);
        cyc(1, 1, 16'h7777, 1);
        chk("mid_rst_cnt", {28'b0, count}, 32'd0);
        chk("mid_rst_dvalid", {31'b0, down_valid}, 32'd0);
        chk("mid_rst_ready", {31'b0, up_ready}, 32'd0);
        cyc(0, 0, 0, 0);
        chk("mid_rst_ready1", {31'b0, up_ready}, 32'd1);

        // random backpressure with an upstream acting on ready two cycles stale
        popped = 0; sent = 0; cycles = 0; hist = '0;
        while ((sent < 40 || q.size() != 0) && cycles < 2000) begin
            logic v;
            hist = {hist[1:0], up_ready};
            v = (sent < 40) && hist[2] && ($urandom_range(3) != 0);
            cyc(0, v, DW'(16'h0100 + sent), 1'($urandom_range(1)));
            if (v) sent++;
            cycles++;
        end
        chk("rand_timeout", {31'b0, cycles < 2000}, 32'd1);
        chk("rand_recv", popped, 32'd40);
        chk("rand_ovf", {31'b0, overflow}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
